// File: rtl/regfile_access_ctrl_if.sv
// rtl/regfile_access_ctrl_if.sv - signal bundle between pipeline requesters, regfile_access_ctrl and the register file
// Ports (slave = controller view, master = environment view):
//   write request   : i_wr_valid, i_wr_addr, i_wr_data      -> o_wr_ready
//   read request    : i_rd_valid, i_rs1_addr, i_rs2_addr    -> o_rd_ready
//   read response   : o_rsp_valid, o_rs1_data, o_rs2_data
//   regfile side    : o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
//                     i_rf_r1data, i_rf_r2data (registered read data)
//   status          : o_busy (zero-fill in progress)
interface regfile_access_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            i_wr_valid;
  logic            o_wr_ready;
  logic [AW-1:0]   i_wr_addr;
  logic [XLEN-1:0] i_wr_data;
  logic            i_rd_valid;
  logic            o_rd_ready;
  logic [AW-1:0]   i_rs1_addr;
  logic [AW-1:0]   i_rs2_addr;
  logic            o_rsp_valid;
  logic [XLEN-1:0] o_rs1_data;
  logic [XLEN-1:0] o_rs2_data;
  logic            o_rf_wen;
  logic [AW-1:0]   o_rf_waddr;
  logic [XLEN-1:0] o_rf_wdata;
  logic [AW-1:0]   o_rf_r1addr;
  logic [AW-1:0]   o_rf_r2addr;
  logic [XLEN-1:0] i_rf_r1data;
  logic [XLEN-1:0] i_rf_r2data;
  logic            o_busy;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data,
    input  i_rd_valid, i_rs1_addr, i_rs2_addr,
    input  i_rf_r1data, i_rf_r2data,
    output o_wr_ready, o_rd_ready,
    output o_rsp_valid, o_rs1_data, o_rs2_data,
    output o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
    output o_busy
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data,
    output i_rd_valid, i_rs1_addr, i_rs2_addr,
    output i_rf_r1data, i_rf_r2data,
    input  o_wr_ready, o_rd_ready,
    input  o_rsp_valid, o_rs1_data, o_rs2_data,
    input  o_rf_wen, o_rf_waddr, o_rf_wdata, o_rf_r1addr, o_rf_r2addr,
    input  o_busy
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - single-port register file access arbiter with zero-fill after reset
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous reset, active low
//   bus     : regfile_access_ctrl_if.slave (write/read requests, read response,
//             regfile write/read port, busy status)
// Writes win over reads, except that a read waiting behind MAX_WR_STREAK
// consecutive write grants is granted next. A write to x0 is accepted and
// discarded without using the regfile port, so a read can share that cycle.
module regfile_access_ctrl #(
  parameter int XLEN          = 32,
  parameter int AW            = 5,
  parameter int MAX_WR_STREAK = 4,
  parameter int INIT_ZERO     = 1
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  regfile_access_ctrl_if.slave bus
);

  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WR_STREAK);
  localparam logic [AW-1:0] LAST_ADDR  = '1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_t          state, state_nxt;
  logic [AW-1:0]   init_ptr;
  logic [SW-1:0]   streak;
  logic            rsp_valid;

  logic            wr_ready, rd_ready, rf_wen;
  logic [AW-1:0]   rf_waddr, rf_r1addr, rf_r2addr;
  logic [XLEN-1:0] rf_wdata;
  logic            wr_x0;

  assign wr_x0 = bus.i_wr_valid && (bus.i_wr_addr == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  // Outputs are forced to zero while reset is held, even though the FSM
  // already sits in INIT, so the regfile sees no write during reset.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    rf_wen    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_r1addr = '0;
    rf_r2addr = '0;
    if (i_rst_n) begin
      rf_r1addr = bus.i_rs1_addr;
      rf_r2addr = bus.i_rs2_addr;
      case (state)
        ST_INIT: begin
          rf_wen   = 1'b1;
          rf_waddr = init_ptr;
          if (init_ptr == LAST_ADDR) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (wr_x0) begin
            wr_ready = 1'b1;
            rd_ready = bus.i_rd_valid;
          end else if (bus.i_wr_valid && bus.i_rd_valid && streak == STREAK_MAX) begin
            rd_ready = 1'b1;
          end else if (bus.i_wr_valid) begin
            wr_ready = 1'b1;
            rf_wen   = 1'b1;
            rf_waddr = bus.i_wr_addr;
            rf_wdata = bus.i_wr_data;
          end else if (bus.i_rd_valid) begin
            rd_ready = 1'b1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_ptr  <= AW'(1);
      streak    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (state == ST_INIT) init_ptr <= init_ptr + 1'b1;
      // Counts write grants a waiting read has lost; saturates at the bound.
      if (rd_ready || !bus.i_rd_valid)
        streak <= '0;
      else if (rf_wen && streak != STREAK_MAX)
        streak <= streak + 1'b1;
      rsp_valid <= rd_ready;
    end
  end

  assign bus.o_wr_ready  = wr_ready;
  assign bus.o_rd_ready  = rd_ready;
  assign bus.o_rf_wen    = rf_wen;
  assign bus.o_rf_waddr  = rf_waddr;
  assign bus.o_rf_wdata  = rf_wdata;
  assign bus.o_rf_r1addr = rf_r1addr;
  assign bus.o_rf_r2addr = rf_r2addr;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rs1_data  = rsp_valid ? bus.i_rf_r1data : '0;
  assign bus.o_rs2_data  = rsp_valid ? bus.i_rf_r2data : '0;
  assign bus.o_busy      = (state == ST_INIT);

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - self-checking bench for regfile_access_ctrl
module tb_regfile_access_ctrl;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int MAXS = 4;

  logic clk;
  logic rst_n;

  regfile_access_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_access_ctrl #(
    .XLEN(XLEN), .AW(AW), .MAX_WR_STREAK(MAXS), .INIT_ZERO(1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_checks = 0;
  int passed_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Register file behaviour: registered read, x0 reads as zero, one access per cycle.
  logic [XLEN-1:0] mem [0:31];
  initial for (int i = 0; i < 32; i++) mem[i] = 32'hA5A5_0000 + i;
  always @(posedge clk) begin
    if (bus.o_rf_wen) mem[bus.o_rf_waddr] <= bus.o_rf_wdata;
    else begin
      bus.i_rf_r1data <= (bus.o_rf_r1addr == 0) ? '0 : mem[bus.o_rf_r1addr];
      bus.i_rf_r2data <= (bus.o_rf_r2addr == 0) ? '0 : mem[bus.o_rf_r2addr];
    end
  end

  // Reference model: architectural register contents, remaining zero-fill
  // cycles, lost-grant count of the waiting read, and the pending response.
  logic [XLEN-1:0] arch [0:31];
  int              m_init_left = 31;
  int              m_streak = 0;
  logic            m_pend = 1'b0;
  logic [XLEN-1:0] m_p1, m_p2;
  logic            e_wr, e_rd, e_wen;
  logic [AW-1:0]   e_waddr;
  logic [XLEN-1:0] e_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", bus.o_busy, 1);
      chk("rst_wr_ready", bus.o_wr_ready, 0);
      chk("rst_rd_ready", bus.o_rd_ready, 0);
      chk("rst_wen", bus.o_rf_wen, 0);
      chk("rst_waddr", bus.o_rf_waddr, 0);
      chk("rst_r1addr", bus.o_rf_r1addr, 0);
      chk("rst_rsp_valid", bus.o_rsp_valid, 0);
      chk("rst_rs1", bus.o_rs1_data, 0);
      m_init_left = 31;
      m_streak    = 0;
      m_pend      = 1'b0;
    end else begin
      e_wr = 0; e_rd = 0; e_wen = 0; e_waddr = 0; e_wdata = 0;
      if (m_init_left > 0) begin
        e_wen   = 1;
        e_waddr = AW'(32 - m_init_left);
      end else if (bus.i_wr_valid && bus.i_wr_addr == 0) begin
        e_wr = 1;
        e_rd = bus.i_rd_valid;
      end else if (bus.i_wr_valid && bus.i_rd_valid && m_streak >= MAXS) begin
        e_rd = 1;
      end else if (bus.i_wr_valid) begin
        e_wr = 1; e_wen = 1; e_waddr = bus.i_wr_addr; e_wdata = bus.i_wr_data;
      end else if (bus.i_rd_valid) begin
        e_rd = 1;
      end
      chk("busy", bus.o_busy, m_init_left > 0);
      chk("wr_ready", bus.o_wr_ready, e_wr);
      chk("rd_ready", bus.o_rd_ready, e_rd);
      chk("rf_wen", bus.o_rf_wen, e_wen);
      chk("rf_waddr", bus.o_rf_waddr, e_waddr);
      chk("rf_wdata", bus.o_rf_wdata, e_wdata);
      chk("rf_r1addr", bus.o_rf_r1addr, bus.i_rs1_addr);
      chk("rf_r2addr", bus.o_rf_r2addr, bus.i_rs2_addr);
      chk("rsp_valid", bus.o_rsp_valid, m_pend);
      chk("rs1_data", bus.o_rs1_data, m_pend ? m_p1 : '0);
      chk("rs2_data", bus.o_rs2_data, m_pend ? m_p2 : '0);
      m_pend = e_rd;
      if (e_rd) begin
        m_p1 = (bus.i_rs1_addr == 0) ? '0 : arch[bus.i_rs1_addr];
        m_p2 = (bus.i_rs2_addr == 0) ? '0 : arch[bus.i_rs2_addr];
      end
      if (e_wen) arch[e_waddr] = e_wdata;
      if (m_init_left > 0) m_init_left--;
      if (e_rd || !bus.i_rd_valid) m_streak = 0;
      else if (e_wen && m_streak < MAXS) m_streak++;
    end
  end

  logic            s_wr, s_rd, s_wen, s_rsp;
  logic [XLEN-1:0] s_rs1, s_rs2;

  task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                      input logic rv, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus.i_wr_valid = wv; bus.i_wr_addr = wa; bus.i_wr_data = wd;
    bus.i_rd_valid = rv; bus.i_rs1_addr = a1; bus.i_rs2_addr = a2;
    @(negedge clk);
    s_wr = bus.o_wr_ready; s_rd = bus.o_rd_ready; s_wen = bus.o_rf_wen;
    s_rsp = bus.o_rsp_valid; s_rs1 = bus.o_rs1_data; s_rs2 = bus.o_rs2_data;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Counts busy cycles, bounded so a stuck zero-fill still ends the run.
  task automatic wait_init(output int n, output logic [AW-1:0] first, output logic [AW-1:0] last);
    logic done = 0;
    n = 0; first = 0; last = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.o_busy) begin
        if (n == 0) first = bus.o_rf_waddr;
        last = bus.o_rf_waddr;
        n++;
      end else done = 1;
      @(posedge clk); #1;
    end
  endtask

  int            n_init;
  logic [AW-1:0] a_first, a_last;
  logic          wr_hist [0:5];
  logic          rd_hist [0:5];
  logic          rsp5;
  logic [XLEN-1:0] rsp5_d;

  initial begin
    rst_n = 1'b0;
    bus.i_wr_valid = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0;
    bus.i_rd_valid = 0; bus.i_rs1_addr = 0; bus.i_rs2_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_busy", bus.o_busy, 1);
    chk("lit_reset_wen", bus.o_rf_wen, 0);
    rst_n = 1'b1;

    wait_init(n_init, a_first, a_last);
    chk("lit_init_cycles", n_init, 31);
    chk("lit_init_first_addr", a_first, 1);
    chk("lit_init_last_addr", a_last, 31);

    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    chk("lit_w5_ready", s_wr, 1);
    chk("lit_w5_wen", s_wen, 1);
    step(0, 0, 0, 1, 5, 0);
    chk("lit_r5_ready", s_rd, 1);
    idle();
    chk("lit_r5_rsp", s_rsp, 1);
    chk("lit_r5_rs1", s_rs1, 32'hDEADBEEF);
    chk("lit_r5_rs2", s_rs2, 0);

    step(1, 3, 32'h0000_0033, 1, 5, 3);
    chk("lit_prio_wr", s_wr, 1);
    chk("lit_prio_rd", s_rd, 0);
    step(0, 0, 0, 1, 5, 3);
    chk("lit_after_rd", s_rd, 1);
    idle();
    chk("lit_after_rs1", s_rs1, 32'hDEADBEEF);
    chk("lit_after_rs2", s_rs2, 32'h33);

    rsp5 = 0; rsp5_d = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, AW'(10 + i), 32'h100 + i, 1, 3, 5);
      wr_hist[i] = s_wr;
      rd_hist[i] = s_rd;
      if (i == 5) begin rsp5 = s_rsp; rsp5_d = s_rs1; end
    end
    for (int i = 0; i < 4; i++) begin
      chk("lit_streak_wr", wr_hist[i], 1);
      chk("lit_streak_rd", rd_hist[i], 0);
    end
    chk("lit_streak5_wr", wr_hist[4], 0);
    chk("lit_streak5_rd", rd_hist[4], 1);
    chk("lit_streak_reset_wr", wr_hist[5], 1);
    chk("lit_streak_reset_rd", rd_hist[5], 0);
    chk("lit_streak_rsp", rsp5, 1);
    chk("lit_streak_rsp_rs1", rsp5_d, 32'h33);
    idle();

    step(0, 0, 0, 1, 10, 13);
    idle();
    chk("lit_x10", s_rs1, 32'h100);
    chk("lit_x13", s_rs2, 32'h103);

    step(1, 0, 32'h1234, 1, 0, 5);
    chk("lit_x0_wr", s_wr, 1);
    chk("lit_x0_rd", s_rd, 1);
    chk("lit_x0_wen", s_wen, 0);
    idle();
    chk("lit_x0_rsp", s_rsp, 1);
    chk("lit_x0_rs1", s_rs1, 0);
    chk("lit_x0_rs2", s_rs2, 32'hDEADBEEF);

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    #1;
    chk("lit_mid_init_addr", bus.o_rf_waddr, 10);
    rst_n = 1'b0;
    #1;
    chk("lit_async_wen", bus.o_rf_wen, 0);
    chk("lit_async_waddr", bus.o_rf_waddr, 0);
    chk("lit_async_busy", bus.o_busy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("lit_restart_addr", bus.o_rf_waddr, 1);
    chk("lit_restart_wen", bus.o_rf_wen, 1);
    wait_init(n_init, a_first, a_last);
    chk("lit_reinit_cycles", n_init, 31);

    step(0, 0, 0, 1, 5, 10);
    idle();
    chk("lit_refill_x5", s_rs1, 0);
    chk("lit_refill_x10", s_rs2, 0);
    idle();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
